bsram_rmw_ctrl: RTL and testbench
=================================

// Module: bsram_rmw_ctrl
// PURPOSE
//   Request front-end sitting directly upstream of the BSRAM word memory. It accepts core load/store requests
//   with byte enables and drives BSRAM's separate read and write ports. BSRAM writes whole words only, so
//   partial stores are done as a 2-cycle read-modify-write. Also keeps saturating access statistics.
// PARAMETERS
//   CORE        0    core index; carried for BSRAM instantiation consistency, no functional effect
//   DATA_WIDTH  32   word width; must be a multiple of 8; NBYTES = DATA_WIDTH/8
//   ADDR_WIDTH  8    BSRAM word-address width; byte address width = ADDR_WIDTH+2 (DATA_WIDTH=32 only)
// PORTS
//   clock         in   1              single clock, all state on rising edge
//   reset         in   1              asynchronous, active-low; all state cleared while low
//   req_valid     in   1              request present
//   req_ready     out  1              request accepted on a cycle with req_valid&&req_ready
//   req_we        in   1              1=store, 0=load
//   req_addr      in   ADDR_WIDTH+2   byte address; bits[1:0] ignored, word = req_addr[ADDR_WIDTH+1:2]
//   req_be        in   NBYTES         store byte enables (ignored on loads)
//   req_wdata     in   DATA_WIDTH     store data, byte lanes aligned to word
//   rsp_valid     out  1              load data valid (one pulse per load; no backpressure)
//   rsp_rdata     out  DATA_WIDTH     load data
//   readEnable    out  1              to BSRAM read port
//   readAddress   out  ADDR_WIDTH     to BSRAM read port
//   readData      in   DATA_WIDTH     from BSRAM; valid the cycle after readEnable
//   writeEnable   out  1              to BSRAM write port
//   writeAddress  out  ADDR_WIDTH     to BSRAM write port
//   writeData     out  DATA_WIDTH     to BSRAM write port
//   stat_loads    out  32             saturating count of accepted loads
//   stat_stores   out  32             saturating count of accepted stores (incl. be=0)
//   stat_rmw      out  32             saturating count of partial stores (RMW performed)
// BEHAVIOUR
//   Reset: state=IDLE; rsp_valid=0; rsp_rdata=0; all stat_* = 0; holding regs cleared.
//   Outputs while reset is low: req_ready=0; readEnable=0; writeEnable=0.
//   FSM states: IDLE, MERGE.
//   IDLE: req_ready=1. On an accepted request:
//     load: readEnable=1, readAddress=word (combinational, same cycle); next cycle rsp_valid=1,
//       rsp_rdata=readData. Back-to-back loads sustain 1/cycle. Stay IDLE.
//     store, be all ones: writeEnable=1, writeAddress=word, writeData=req_wdata same cycle. Stay IDLE.
//     store, be==0: no SRAM access; stat_stores increments. Stay IDLE.
//     store, partial be: readEnable=1 on the word; latch addr/be/wdata -> MERGE.
//   MERGE (1 cycle): req_ready=0; readEnable=0; writeEnable=1; writeAddress=latched word.
//     writeData byte i = be[i] ? wdata byte i : readData byte i. -> IDLE.
//   rsp_valid is a registered 1-cycle pulse, only for loads; stores never produce a response.
//   A load issued the cycle after any write to the same word returns the new data: the write commits at
//     the edge ending the write cycle, and the read port samples after it.
//   Read and write ports are never driven to the same address in the same cycle; req_ready=0 in MERGE
//     guarantees this.
//   Stats: each counter increments on accept and holds at 32'hFFFF_FFFF.
//   Reset low mid-MERGE: pending write is dropped (writeEnable=0 immediately), FSM returns to IDLE.
//   Reset low while a load response is pending: that rsp_valid is suppressed.
//   req_* are don't-care when req_valid=0; no SRAM enable asserts without an accepted request except in MERGE.
// TESTING
//   T1 reset: reset=0 mid-traffic -> rsp_valid=0, writeEnable=0, stat_*=0, req_ready=0 until reset=1.
//   T2 full store then load: store addr 0x10, be=4'hF, data 0xDEADBEEF; next cycle load 0x10
//      -> writeEnable pulse at word 4; rsp_valid one cycle after load with 0xDEADBEEF.
//   T3 partial store: word 4 holds 0xDEADBEEF; store be=4'b0101, data 0x11223344
//      -> req_ready low 1 cycle; written word = 0xDE22BE44; stat_rmw=1.
//   T4 back-to-back loads to words 0..7: 8 consecutive accepts
//      -> 8 consecutive rsp_valid pulses, in order, each 1 cycle after its request.
//   T5 be=0 store then load of that word -> no writeEnable; data unchanged; stat_stores increments.
//   T6 counter saturation: preload stat_loads to 32'hFFFF_FFFE via force, issue 3 loads -> holds at FFFF_FFFF.

Source files
------------

// File: rtl/bsram_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// bsram_rmw_ctrl
//   Request front-end for the BSRAM word memory. It accepts core load/store
//   requests with byte enables and drives BSRAM's separate read and write
//   ports. BSRAM only writes whole words, so a partial store is done as a
//   two-cycle read-modify-write: read the word, then merge and write it back.
//   Saturating access statistics are kept as well.
//
// Ports
//   clock                  single clock, all state on the rising edge
//   reset                  asynchronous, active-low; clears all state
//   req_valid/req_ready    request handshake (accept = valid && ready)
//   req_we                 1 = store, 0 = load
//   req_addr               byte address; word = req_addr[ADDR_WIDTH+1:2]
//   req_be / req_wdata     store byte enables and word-aligned store data
//   rsp_valid / rsp_rdata  one-cycle load response pulse and its data
//   readEnable/readAddress/readData     BSRAM read port (data 1 cycle later)
//   writeEnable/writeAddress/writeData  BSRAM write port
//   stat_loads/stat_stores/stat_rmw     saturating accept counters
// -----------------------------------------------------------------------------
module bsram_rmw_ctrl #(
  parameter int CORE       = 0,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH+1:0]   req_addr,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    readEnable,
  output logic [ADDR_WIDTH-1:0]   readAddress,
  input  logic [DATA_WIDTH-1:0]   readData,
  output logic                    writeEnable,
  output logic [ADDR_WIDTH-1:0]   writeAddress,
  output logic [DATA_WIDTH-1:0]   writeData,
  output logic [31:0]             stat_loads,
  output logic [31:0]             stat_stores,
  output logic [31:0]             stat_rmw
);

  localparam int NBYTES = DATA_WIDTH / 8;

  // The core index only matters to whoever instantiates the BSRAM.
  localparam int unused_core = CORE;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [NBYTES-1:0]       be_q, be_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_hold_q, rsp_hold_d;
  logic [31:0]             stat_loads_q, stat_loads_d;
  logic [31:0]             stat_stores_q, stat_stores_d;
  logic [31:0]             stat_rmw_q, stat_rmw_d;

  logic [ADDR_WIDTH-1:0]   req_word;
  logic [DATA_WIDTH-1:0]   merge_data;
  logic                    be_full;
  logic                    be_zero;
  logic                    accept;
  logic                    unused_addr_lsbs;

  assign req_word         = req_addr[ADDR_WIDTH+1:2];
  assign be_full          = &req_be;
  assign be_zero          = ~|req_be;
  // Sub-word address bits carry no meaning for a word memory.
  assign unused_addr_lsbs = ^req_addr[1:0];

  // Byte-lane merge for the write-back half of a read-modify-write: the
  // latched store bytes win, the rest come from the word read last cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_merge
      assign merge_data[gi*8 +: 8] = be_q[gi] ? wdata_q[gi*8 +: 8]
                                              : readData[gi*8 +: 8];
    end
  endgenerate

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    rsp_valid_d   = 1'b0;
    // readData belongs to the previous cycle's read; keep it once shown so
    // rsp_rdata stays stable between responses.
    rsp_hold_d    = rsp_valid_q ? readData : rsp_hold_q;
    stat_loads_d  = stat_loads_q;
    stat_stores_d = stat_stores_q;
    stat_rmw_d    = stat_rmw_q;

    accept        = 1'b0;
    req_ready     = 1'b0;
    readEnable    = 1'b0;
    readAddress   = req_word;
    writeEnable   = 1'b0;
    writeAddress  = req_word;
    writeData     = req_wdata;

    case (state_q)
      ST_IDLE: begin
        // reset gates the combinational outputs so nothing is accepted or
        // driven onto the SRAM while reset is held low.
        req_ready = reset;
        accept    = req_valid && reset;
        if (accept) begin
          if (!req_we) begin
            readEnable   = 1'b1;
            rsp_valid_d  = 1'b1;
            stat_loads_d = sat_inc(stat_loads_q);
          end else begin
            stat_stores_d = sat_inc(stat_stores_q);
            if (be_full) begin
              writeEnable = 1'b1;
            end else if (!be_zero) begin
              // Partial store: fetch the old word now, merge next cycle.
              readEnable = 1'b1;
              addr_d     = req_word;
              be_d       = req_be;
              wdata_d    = req_wdata;
              stat_rmw_d = sat_inc(stat_rmw_q);
              state_d    = ST_MERGE;
            end
          end
        end
      end

      ST_MERGE: begin
        // req_ready stays low here, so the read port is idle and can never
        // collide with the write-back address.
        writeEnable  = reset;
        writeAddress = addr_q;
        writeData    = merge_data;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      be_q          <= '0;
      wdata_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_hold_q    <= '0;
      stat_loads_q  <= '0;
      stat_stores_q <= '0;
      stat_rmw_q    <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      be_q          <= be_d;
      wdata_q       <= wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_hold_q    <= rsp_hold_d;
      stat_loads_q  <= stat_loads_d;
      stat_stores_q <= stat_stores_d;
      stat_rmw_q    <= stat_rmw_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  // Read data arrives the cycle after readEnable, which is exactly the
  // response cycle, so it is passed straight through while rsp_valid is high.
  assign rsp_rdata   = rsp_valid_q ? readData : rsp_hold_q;
  assign stat_loads  = stat_loads_q;
  assign stat_stores = stat_stores_q;
  assign stat_rmw    = stat_rmw_q;

endmodule

// File: tb/tb_bsram_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bsram_rmw_ctrl
//   Bench for bsram_rmw_ctrl with a behavioural BSRAM (registered read,
//   write commits at the clock edge). A vector table drives loads and stores;
//   expected load data is pushed to a scoreboard queue when a load is
//   accepted and popped when rsp_valid appears, together with the cycle it
//   must appear in. Hand-written sequences cover the read-modify-write stall,
//   counter saturation and reset in the middle of traffic.
// -----------------------------------------------------------------------------
module tb_bsram_rmw_ctrl;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clock;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW+1:0] req_addr;
  logic [3:0]    req_be;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          readEnable;
  logic [AW-1:0] readAddress;
  logic [DW-1:0] readData;
  logic          writeEnable;
  logic [AW-1:0] writeAddress;
  logic [DW-1:0] writeData;
  logic [31:0]   stat_loads;
  logic [31:0]   stat_stores;
  logic [31:0]   stat_rmw;

  bsram_rmw_ctrl #(.CORE(0), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_be       (req_be),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .readEnable   (readEnable),
    .readAddress  (readAddress),
    .readData     (readData),
    .writeEnable  (writeEnable),
    .writeAddress (writeAddress),
    .writeData    (writeData),
    .stat_loads   (stat_loads),
    .stat_stores  (stat_stores),
    .stat_rmw     (stat_rmw)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural BSRAM: registered read, whole-word write.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_q;
  always @(posedge clock) begin
    if (writeEnable) mem[writeAddress] <= writeData;
    if (readEnable)  rd_q <= mem[readAddress];
  end
  assign readData = rd_q;

  // Watchdog: the bench must always terminate.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_data;   // load: response data; store: written word
    int          exp_writes; // store: number of writeEnable cycles
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[$];
  int          checks;
  int          errors;
  int          cyc;
  int          wr_count;
  logic [7:0]  wr_addr_last;
  logic [31:0] wr_data_last;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Called once per cycle at the falling edge: records write-port activity
  // and retires load responses against the scoreboard.
  task automatic snoop();
    exp_t e;
    if (writeEnable) begin
      wr_count++;
      wr_addr_last = writeAddress;
      wr_data_last = writeData;
      if (readEnable) begin
        checks++;
        if (readAddress == writeAddress) begin
          errors++;
          $display("FAIL port_collision: read and write both at word %h", writeAddress);
        end
      end
    end
    if (rsp_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got rsp_valid data=%h with nothing outstanding", rsp_rdata);
      end else begin
        e = sb_q.pop_front();
        if (rsp_rdata !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL rsp_data: got=%h at cycle %0d expected=%h at cycle %0d",
                   rsp_rdata, cyc, e.data, e.cyc);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clock);
    snoop();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  // Presents one request and waits (bounded) for it to be accepted. Returns
  // one time unit after the accepting edge.
  task automatic issue(input logic we, input logic [9:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] exp, output int waits);
    logic rdy;
    exp_t e;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_be    = be;
    req_wdata = wd;
    waits     = 0;
    rdy       = 1'b0;
    while (!rdy && waits < 8) begin
      @(negedge clock);
      snoop();
      rdy = req_ready;
      if (rdy && !we) begin
        e.data = exp;
        e.cyc  = cyc + 1;
        sb_q.push_back(e);
      end
      @(posedge clock);
      #1;
      cyc++;
      if (!rdy) waits++;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: request we=%0d addr=%h never accepted", we, addr);
    end
    req_valid = 1'b0;
    $display("txn cyc=%0d we=%0d addr=%h be=%h wdata=%h exp=%h waits=%0d",
             cyc, we, addr, be, wd, exp, waits);
  endtask

  function automatic void add(input logic we, input logic [9:0] addr, input logic [3:0] be,
                              input logic [31:0] wd, input logic [31:0] exp, input int nw);
    vec_t v;
    v.we = we; v.addr = addr; v.be = be; v.wdata = wd; v.exp_data = exp; v.exp_writes = nw;
    vecs.push_back(v);
  endfunction

  initial begin
    vec_t        v;
    int          w0;
    int          waits;
    int          n_loads;
    int          n_stores;
    int          n_rmw;
    logic [31:0] d;

    checks = 0; errors = 0; cyc = 0; wr_count = 0;
    wr_addr_last = '0; wr_data_last = '0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0;

    // Stimulus table.
    add(1'b1, 10'h010, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF, 1);  // full store word 4
    add(1'b0, 10'h010, 4'h0, 32'h0,       32'hDEADBEEF, 0);   // load right after write
    add(1'b1, 10'h010, 4'h5, 32'h11223344, 32'hDE22BE44, 1);  // partial store
    add(1'b0, 10'h010, 4'h0, 32'h0,       32'hDE22BE44, 0);
    add(1'b1, 10'h013, 4'h0, 32'hFFFFFFFF, 32'h0,       0);   // be=0 store, no write
    add(1'b0, 10'h012, 4'h0, 32'h0,       32'hDE22BE44, 0);   // low addr bits ignored
    for (int i = 0; i < 8; i++) begin
      d = 32'hC0DE0000 | i;
      add(1'b1, 10'(i * 4), 4'hF, d, d, 1);
    end
    for (int i = 0; i < 8; i++) begin
      d = 32'hC0DE0000 | i;
      add(1'b0, 10'(i * 4), 4'h0, 32'h0, d, 0);              // back-to-back loads
    end
    add(1'b1, 10'h008, 4'h8, 32'hAABBCCDD, 32'hAADE0002, 1);
    add(1'b0, 10'h008, 4'h0, 32'h0,       32'hAADE0002, 0);
    add(1'b1, 10'h00C, 4'h6, 32'h11223344, 32'hC0223303, 1);
    add(1'b0, 10'h00C, 4'h0, 32'h0,       32'hC0223303, 0);
    add(1'b1, 10'h3FC, 4'hF, 32'h0BADF00D, 32'h0BADF00D, 1);  // top word
    add(1'b0, 10'h3FF, 4'h0, 32'h0,       32'h0BADF00D, 0);

    // Reset state, with a request presented while reset is low.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h010;
    @(negedge clock);
    snoop();
    chk("reset_req_ready", {31'b0, req_ready}, 32'd0);
    chk("reset_readEnable", {31'b0, readEnable}, 32'd0);
    chk("reset_writeEnable", {31'b0, writeEnable}, 32'd0);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_stat_loads", stat_loads, 32'd0);
    chk("reset_stat_stores", stat_stores, 32'd0);
    chk("reset_stat_rmw", stat_rmw, 32'd0);
    @(posedge clock);
    #1;
    cyc++;
    reset = 1'b1;
    req_valid = 1'b0;
    tick();

    // Table-driven part.
    n_loads = 0; n_stores = 0; n_rmw = 0;
    foreach (vecs[i]) begin
      v = vecs[i];
      if (v.we) begin
        n_stores++;
        if (v.be != 4'h0 && v.be != 4'hF) n_rmw++;
        w0 = wr_count;
        issue(v.we, v.addr, v.be, v.wdata, v.exp_data, waits);
        tick();
        chk($sformatf("vec%0d_write_count", i), 32'(wr_count - w0), 32'(v.exp_writes));
        if (v.exp_writes == 1) begin
          chk($sformatf("vec%0d_write_addr", i), {24'b0, wr_addr_last}, {24'b0, v.addr[9:2]});
          chk($sformatf("vec%0d_write_data", i), wr_data_last, v.exp_data);
        end
      end else begin
        n_loads++;
        issue(v.we, v.addr, v.be, v.wdata, v.exp_data, waits);
        chk($sformatf("vec%0d_accept_wait", i), 32'(waits), 32'd0);
      end
    end
    idle(3);
    chk("table_stat_loads", stat_loads, 32'(n_loads));
    chk("table_stat_stores", stat_stores, 32'(n_stores));
    chk("table_stat_rmw", stat_rmw, 32'(n_rmw));

    // Partial store: one stall cycle, merged word written to the latched address.
    issue(1'b1, 10'h014, 4'hF, 32'h12345678, 32'h0, waits);
    idle(1);
    issue(1'b1, 10'h014, 4'h3, 32'hAAAABBCC, 32'h0, waits);
    @(negedge clock);
    snoop();
    chk("merge_req_ready", {31'b0, req_ready}, 32'd0);
    chk("merge_writeEnable", {31'b0, writeEnable}, 32'd1);
    chk("merge_writeAddress", {24'b0, writeAddress}, 32'h5);
    chk("merge_writeData", writeData, 32'h1234BBCC);
    @(posedge clock);
    #1;
    cyc++;
    @(negedge clock);
    snoop();
    chk("after_merge_req_ready", {31'b0, req_ready}, 32'd1);
    chk("after_merge_writeEnable", {31'b0, writeEnable}, 32'd0);
    @(posedge clock);
    #1;
    cyc++;

    // Counter saturation.
    force dut.stat_loads_q = 32'hFFFF_FFFE;
    #1;
    release dut.stat_loads_q;
    chk("sat_preload", stat_loads, 32'hFFFF_FFFE);
    issue(1'b0, 10'h014, 4'h0, 32'h0, 32'h1234BBCC, waits);
    chk("sat_first", stat_loads, 32'hFFFF_FFFF);
    issue(1'b0, 10'h014, 4'h0, 32'h0, 32'h1234BBCC, waits);
    issue(1'b0, 10'h014, 4'h0, 32'h0, 32'h1234BBCC, waits);
    idle(2);
    chk("sat_hold", stat_loads, 32'hFFFF_FFFF);

    // Reset while a load response is pending: the response must not appear.
    issue(1'b0, 10'h014, 4'h0, 32'h0, 32'h1234BBCC, waits);
    reset = 1'b0;
    void'(sb_q.pop_back());
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h014;
    @(negedge clock);
    snoop();
    chk("rst_load_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_load_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_load_readEnable", {31'b0, readEnable}, 32'd0);
    chk("rst_load_stat_loads", stat_loads, 32'd0);
    chk("rst_load_stat_stores", stat_stores, 32'd0);
    chk("rst_load_stat_rmw", stat_rmw, 32'd0);
    @(posedge clock);
    #1;
    cyc++;
    reset = 1'b1;
    idle(1);

    // Reset in the middle of a read-modify-write: the write-back is dropped.
    issue(1'b1, 10'h014, 4'hC, 32'h99990000, 32'h0, waits);
    reset = 1'b0;
    #1;
    chk("rst_merge_writeEnable", {31'b0, writeEnable}, 32'd0);
    chk("rst_merge_req_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clock);
    #1;
    cyc++;
    reset = 1'b1;
    issue(1'b0, 10'h014, 4'h0, 32'h0, 32'h1234BBCC, waits);
    chk("rst_merge_idle_accept", 32'(waits), 32'd0);
    idle(3);
    chk("rst_merge_stat_loads", stat_loads, 32'd1);
    chk("rst_merge_stat_stores", stat_stores, 32'd0);
    chk("drain_scoreboard", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
